// File: rtl/rv32_mod_mem_arbiter.sv
// rv32_mod_mem_arbiter: shares the external memory bus between fetch and LSU, LSU first, one transaction at a time
module rv32_mod_mem_arbiter #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_if_req,
    input  logic [XLEN-1:0] i_if_addr,
    input  logic            i_if_kill,
    output logic            o_if_valid,
    output logic [XLEN-1:0] o_if_rdata,
    output logic            o_if_error,
    input  logic            i_lsu_req,
    input  logic [XLEN-1:0] i_lsu_addr,
    input  logic            i_lsu_we,
    input  logic [3:0]      i_lsu_be,
    input  logic [XLEN-1:0] i_lsu_wdata,
    output logic            o_lsu_valid,
    output logic [XLEN-1:0] o_lsu_rdata,
    output logic            o_lsu_error,
    output logic            o_bus_req,
    output logic [XLEN-1:0] o_bus_addr,
    output logic            o_bus_we,
    output logic [3:0]      o_bus_be,
    output logic [XLEN-1:0] o_bus_wdata,
    input  logic            i_bus_ack,
    input  logic [XLEN-1:0] i_bus_rdata,
    input  logic            i_bus_err
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LSU, RESP} state_t;
    localparam logic [15:0] T_MAX = 16'(TIMEOUT_CYCLES - 1);

    state_t          r_state, w_next;
    logic [15:0]     r_cnt;
    logic            r_kill, r_owner_lsu, r_err, r_we;
    logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
    logic [3:0]      r_be;
    logic            w_busy, w_timeout, w_grant_lsu, w_grant_if, w_if_valid, w_lsu_valid;

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;

    always_comb begin
        w_busy      = r_state == BUSY_IF || r_state == BUSY_LSU;
        w_timeout   = w_busy && !i_bus_ack && r_cnt == T_MAX;
        w_grant_lsu = r_state == IDLE && i_lsu_req;
        w_grant_if  = r_state == IDLE && !i_lsu_req && i_if_req && !i_if_kill;
        w_next      = w_grant_lsu ? BUSY_LSU :
                      w_grant_if ? BUSY_IF :
                      (w_busy && (i_bus_ack || w_timeout)) ? RESP :
                      (r_state == RESP) ? IDLE : r_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_be        <= 4'h0;
            r_wdata     <= '0;
            r_owner_lsu <= 1'b0;
            r_cnt       <= 16'd0;
            r_kill      <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_grant_lsu) begin
                r_addr      <= i_lsu_addr;
                r_we        <= i_lsu_we;
                r_be        <= i_lsu_be;
                r_wdata     <= i_lsu_wdata;
                r_owner_lsu <= 1'b1;
            end else if (w_grant_if) begin
                r_addr      <= i_if_addr;
                r_we        <= 1'b0;
                r_be        <= 4'hF;
                r_wdata     <= '0;
                r_owner_lsu <= 1'b0;
            end
            r_cnt <= w_busy ? r_cnt + 16'd1 : 16'd0;
            // killed fetches still finish on the bus; only the response is dropped
            r_kill <= (w_next == IDLE) ? 1'b0 : r_kill | (r_state == BUSY_IF && i_if_kill);
            if (w_busy && i_bus_ack) begin
                r_rdata <= i_bus_rdata;
                r_err   <= i_bus_err;
            end else if (w_timeout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    assign w_lsu_valid = r_state == RESP && r_owner_lsu;
    assign w_if_valid  = r_state == RESP && !r_owner_lsu && !r_kill && !i_if_kill;
    assign o_lsu_valid = w_lsu_valid;
    assign o_lsu_rdata = w_lsu_valid ? r_rdata : '0;
    assign o_lsu_error = w_lsu_valid && r_err;
    assign o_if_valid  = w_if_valid;
    assign o_if_rdata  = w_if_valid ? r_rdata : '0;
    assign o_if_error  = w_if_valid && r_err;
    assign o_bus_req   = w_busy;
    assign o_bus_addr  = r_addr;
    assign o_bus_we    = r_we;
    assign o_bus_be    = r_be;
    assign o_bus_wdata = r_wdata;
endmodule

// File: doc/rv32_mod_mem_arbiter.md
Name: rv32_mod_mem_arbiter

Overview:
- Shares the single external memory bus between instruction fetch (IF) and the load/store unit (LSU) of the rv32imc core.
- Fixed priority LSU > IF, one outstanding transaction, registered request and response paths.
- Bus timeout with error reporting, and fetch-kill on taken branches.
- Sits between the IF/LSU units and the top-level memory port; its `*_valid` pulses feed the stall controller's `is_instr_new` and `io_lsu_valid` inputs.

Parameters:
- XLEN, 32, address/data width.
- TIMEOUT_CYCLES, 255, cycles in a BUSY state without bus_ack before the transaction is aborted with error (1..2^16-1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- if_req  in  1  fetch request; held with if_addr until if_valid
- if_addr  in  XLEN  fetch address
- if_kill  in  1  discard in-flight/pending fetch result (taken branch)
- if_valid  out  1  1-cycle pulse, fetch response
- if_rdata  out  XLEN  fetch data, valid with if_valid
- if_error  out  1  fetch bus error/timeout, valid with if_valid
- lsu_req  in  1  load/store request; held with attributes until lsu_valid
- lsu_addr  in  XLEN  access address
- lsu_we  in  1  1 = store
- lsu_be  in  4  byte enables
- lsu_wdata  in  XLEN  store data
- lsu_valid  out  1  1-cycle pulse, LSU response
- lsu_rdata  out  XLEN  load data, valid with lsu_valid
- lsu_error  out  1  bus error/timeout, valid with lsu_valid
- bus_req  out  1  bus request, held until bus_ack or timeout
- bus_addr  out  XLEN  registered address
- bus_we  out  1  registered write enable
- bus_be  out  4  registered byte enables; 4'hF for fetches
- bus_wdata  out  XLEN  registered write data; 0 for fetches
- bus_ack  in  1  1-cycle completion strobe
- bus_rdata  in  XLEN  read data, valid with bus_ack
- bus_err  in  1  bus error, valid with bus_ack

Behaviour:
- States: IDLE, BUSY_IF, BUSY_LSU, RESP. Reset (async) forces IDLE, with:
  - all outputs 0;
  - owner, timeout counter and kill flag cleared;
  - bus_req dropping immediately.
- IDLE:
  - lsu_req=1 latches the LSU attributes into the bus registers and enters BUSY_LSU.
  - Otherwise, if_req=1 && !if_kill latches if_addr (we=0, be=4'hF, wdata=0) and enters BUSY_IF.
  - lsu_req and if_req in the same cycle: LSU is granted; IF waits.
- BUSY_*:
  - bus_req=1 and the timeout counter increments each cycle; the counter starts at 0 on entry.
  - bus_req first rises the cycle after grant.
  - bus_ack=1: capture bus_rdata and bus_err into response registers, drop bus_req, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: abort. Drop bus_req, rdata=0, error=1, go to RESP.
  - bus_ack and timeout in the same cycle: ack wins.
- RESP (exactly 1 cycle):
  - The owner's `*_valid`=1, with `*_rdata`/`*_error` from the response registers; the other requester's outputs stay 0. Then IDLE.
  - No grant is issued in RESP. The requester must drop `*_req` in its valid cycle, or it is treated as a new request in IDLE.
- if_kill:
  - In BUSY_IF: sets the kill flag. The bus transaction still completes; in RESP, if_valid is suppressed (0).
  - In RESP with owner IF: suppresses that same-cycle pulse.
  - In IDLE: blocks the IF grant that cycle.
  - The flag clears on return to IDLE.
- Latency: request to valid = 2 + bus wait cycles.
  - Minimum 3 cycles: grant, bus cycle with same-cycle ack, RESP.
- Throughput: back-to-back transactions have 1 IDLE cycle between RESP and the next bus_req rise, i.e. the next grant happens in IDLE.
- The `*_rdata` and `*_error` outputs are 0 whenever the corresponding `*_valid` is 0.

Test Plan:
- IF alone: if_req, if_addr=0x0000_0100; bus_ack on 1st bus_req cycle with rdata=0x0000_0013 -> bus_addr=0x100, bus_be=4'hF, bus_we=0; if_valid 1 cycle with if_rdata=0x13, 3 cycles after request.
- Contention: if_req and lsu_req (store, addr 0x2000, be=4'b0011, wdata=0xDEAD_BEEF) in the same cycle -> store issued first with exact attributes; lsu_valid; then the fetch granted after RESP+IDLE; if_valid follows.
- Timeout: TIMEOUT_CYCLES=4, lsu load, bus_ack never asserted -> bus_req high exactly 4 cycles; lsu_valid with lsu_error=1, lsu_rdata=0; next request serviced normally.
- Kill: fetch in BUSY_IF, if_kill pulsed, bus_ack 3 cycles later -> no if_valid pulse; state returns IDLE; a subsequent fetch at 0x200 returns normally.
- Bus error: lsu load, bus_ack with bus_err=1, bus_rdata=0x1234 -> lsu_valid, lsu_error=1, lsu_rdata=0x1234.
- Reset mid-transaction: assert reset while BUSY_LSU -> bus_req and all valids 0 the same cycle (async); after release, a late bus_ack is ignored; an if_req is then granted normally.
